// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, common command bytes and
// frame construction used by the host transmitter.
package ps2_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_START,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    localparam logic [7:0] ACK      = 8'hFA;
    localparam logic [7:0] RESEND   = 8'hFE;
    localparam logic [7:0] SET_LEDS = 8'hED;

    // Shift-out order is LSB first: data[0..7], odd parity, stop.
    function automatic logic [9:0] make_frame(input logic [7:0] d);
        return {1'b1, ~^d, d};
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Hysteresis filter for one PS/2 line: the output follows the synchronised input
// only after FILTER_LEN consecutive samples disagree with it.
module ps2_line_filter #(
    parameter int FILTER_LEN = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic filt
);
    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // Two-flop synchroniser first: the pad is driven by the device's own clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= 2'b11;
            cnt  <= '0;
            filt <= 1'b1;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == filt) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                filt <= sync[1];
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, issues request-to-send,
// shifts a byte out on device clock falling edges and checks the device ACK.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ         = 50_000_000,
    parameter int INHIBIT_CYCLES = 5_000,
    parameter int TIMEOUT_CYCLES = 750_000,
    parameter int FILTER_LEN     = 16
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic       busy
);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

    state_t        state, state_nx;
    logic [WW-1:0] wdog;
    logic [9:0]    shreg;
    logic [3:0]    bitcnt;
    logic          data_drv;
    logic          ack_ok;
    logic          clk_f, data_f, clk_prev;
    logic          fall, timeout, accept;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk (CLOCK_50),
        .rst (reset),
        .raw (ps2_clk_in),
        .filt(clk_f)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
        .clk (CLOCK_50),
        .rst (reset),
        .raw (ps2_data_in),
        .filt(data_f)
    );

    assign fall    = clk_prev & ~clk_f;
    // The watchdog also times the inhibit pulse: both count from INHIBIT entry.
    assign timeout = (state != S_IDLE) && (wdog == WW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        tx_done  = 1'b0;
        tx_error = 1'b0;
        case (state)
            S_IDLE: if (tx_valid) begin
                accept   = 1'b1;
                state_nx = S_INHIBIT;
            end
            S_INHIBIT: if (wdog == WW'(INHIBIT_CYCLES - 1)) state_nx = S_START;
            S_START:   state_nx = S_SHIFT;
            S_SHIFT:   if (fall && bitcnt == 4'd9) state_nx = S_ACK;
            S_ACK: if (fall) begin
                state_nx = S_WAIT_IDLE;
                tx_error = data_f;
            end
            S_WAIT_IDLE: if (clk_f && data_f) begin
                state_nx = S_IDLE;
                tx_done  = ack_ok;
            end
            default: state_nx = S_IDLE;
        endcase
        // A NACK already reported its error; a later timeout must not pulse again.
        if (timeout) begin
            state_nx = S_IDLE;
            tx_done  = 1'b0;
            tx_error = !(state == S_WAIT_IDLE && !ack_ok);
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            wdog     <= '0;
            shreg    <= '0;
            bitcnt   <= '0;
            data_drv <= 1'b0;
            ack_ok   <= 1'b0;
            clk_prev <= 1'b1;
        end else begin
            state    <= state_nx;
            clk_prev <= clk_f;
            if (accept) begin
                shreg  <= make_frame(tx_data);
                wdog   <= '0;
                bitcnt <= '0;
                ack_ok <= 1'b0;
            end else if (state != S_IDLE) begin
                wdog <= wdog + 1'b1;
            end
            case (state)
                S_START: begin
                    data_drv <= 1'b1;
                    bitcnt   <= '0;
                end
                S_SHIFT: if (fall) begin
                    data_drv <= ~shreg[0];
                    shreg    <= {1'b0, shreg[9:1]};
                    bitcnt   <= bitcnt + 1'b1;
                end
                S_ACK: if (fall) ack_ok <= ~data_f;
                default: ;
            endcase
            if (state_nx == S_IDLE) data_drv <= 1'b0;
        end
    end

    assign tx_ready    = (state == S_IDLE);
    assign busy        = (state != S_IDLE);
    assign ps2_clk_oe  = (state == S_INHIBIT);
    assign ps2_data_oe = data_drv &&
                         (state == S_START || state == S_SHIFT || state == S_ACK);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed/randomised bench for ps2_host_tx with an open-drain bus and a
// behavioural PS/2 device that clocks frames, records bits and ACKs.
module tb_ps2_host_tx;
    localparam int INH  = 40;
    localparam int TMO  = 2000;
    localparam int FLEN = 8;
    localparam int H    = 30;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready, tx_done, tx_error, busy;
    logic       dev_clk, dev_data;

    int n_pass  = 0;
    int n_total = 0;

    int cyc = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0;
    int oe_run = 0, last_run = 0, err_cyc = 0, acc_cyc = 0;

    always #5 clk = ~clk;

    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO),
        .FILTER_LEN    (FLEN)
    ) dut (
        .CLOCK_50   (clk),
        .reset      (reset),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_done    (tx_done),
        .tx_error   (tx_error),
        .busy       (busy)
    );

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (tx_done) done_cnt <= done_cnt + 1;
        if (tx_error) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc;
        end
        if (tx_done && tx_error) both_cnt <= both_cnt + 1;
        if (tx_valid && tx_ready && !reset) acc_cyc <= cyc;
        if (ps2_clk_oe) oe_run <= oe_run + 1;
        else if (oe_run != 0) begin
            last_run <= oe_run;
            oe_run   <= 0;
        end
    end

    initial begin
        #(10 * 60000);
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Frame as the device sees it: start, data LSB first, odd parity, stop.
    function automatic logic [10:0] ref_frame(input logic [7:0] d);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, d, 1'b0};
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!tx_ready && n < 3000) begin
            tick(1);
            n++;
        end
        check("ready", tx_ready, 1);
    endtask

    task automatic send(input logic [7:0] d);
        wait_ready();
        tx_data  = d;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
    endtask

    task automatic device_frame(input bit ack, input bit glitch, input int n_edges,
                                output logic [10:0] bits);
        int n = 0;
        bits = '0;
        while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && n < 1000) begin
            tick(1);
            n++;
        end
        check("rts_seen", {ps2_clk_oe, ps2_data_oe}, 2'b01);
        for (int i = 0; i < n_edges; i++) begin
            if (glitch && i >= 2 && i < 8) begin
                tick(14);
                dev_clk = 1'b0;
                tick(5);
                dev_clk = 1'b1;
                tick(H - 19);
            end else begin
                tick(H);
            end
            bits[i] = ps2_data_in;
            if (i == 10 && ack) begin
                dev_data = 1'b0;
                tick(H);
            end
            dev_clk = 1'b0;
            tick(H);
            dev_clk = 1'b1;
        end
        tick(H);
        dev_data = 1'b1;
    endtask

    initial begin
        logic [7:0]  b;
        logic [10:0] bits;
        logic [7:0]  fixed [3];
        int d0, e0;
        fixed[0] = 8'hED;
        fixed[1] = 8'h07;
        fixed[2] = 8'h00;

        reset = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
        dev_clk = 1'b1; dev_data = 1'b1;
        tick(3);
        check("reset_outputs",
              {tx_ready, busy, ps2_clk_oe, ps2_data_oe, tx_done, tx_error}, 6'b100000);
        reset = 1'b0;
        tick(20);

        // Device clocking while idle must not start anything.
        d0 = done_cnt; e0 = err_cnt;
        repeat (4) begin
            dev_clk = 1'b0; tick(H);
            dev_clk = 1'b1; tick(H);
        end
        check("idle_clk_state", {busy, tx_ready}, 2'b01);
        check("idle_clk_pulses", (done_cnt - d0) + (err_cnt - e0), 0);

        for (int k = 0; k < 7; k++) begin
            b = (k < 3) ? fixed[k] : 8'($urandom);
            d0 = done_cnt; e0 = err_cnt;
            send(b);
            if (k == 0) begin
                tx_valid = 1'b1;
                tx_data  = 8'($urandom);
                tick(10);
                tx_valid = 1'b0;
            end
            device_frame(1'b1, 1'b0, 11, bits);
            wait_ready();
            check("frame_bits", bits, ref_frame(b));
            check("frame_done", done_cnt - d0, 1);
            check("frame_err", err_cnt - e0, 0);
            if (k == 0) begin
                check("inhibit_len", last_run, INH);
                tick(100);
                check("no_requeue", busy, 0);
            end
        end

        // Device leaves data high at the ACK clock.
        d0 = done_cnt; e0 = err_cnt;
        send(8'($urandom));
        device_frame(1'b0, 1'b0, 11, bits);
        wait_ready();
        check("nack_err", err_cnt - e0, 1);
        check("nack_done", done_cnt - d0, 0);

        // Silent device: watchdog fires.
        d0 = done_cnt; e0 = err_cnt;
        send(8'($urandom));
        for (int n = 0; n < TMO + 100 && err_cnt == e0; n++) tick(1);
        tick(2);
        check("tmo_err", err_cnt - e0, 1);
        check("tmo_done", done_cnt - d0, 0);
        check("tmo_latency", err_cyc - acc_cyc, TMO);
        check("tmo_inhibit_len", last_run, INH);
        check("tmo_released", {ps2_clk_oe, ps2_data_oe, tx_ready}, 3'b001);

        // Short clock glitches during the shift phase.
        d0 = done_cnt; e0 = err_cnt;
        b = 8'($urandom);
        send(b);
        device_frame(1'b1, 1'b1, 11, bits);
        wait_ready();
        check("glitch_bits", bits, ref_frame(b));
        check("glitch_done", done_cnt - d0, 1);
        check("glitch_err", err_cnt - e0, 0);

        // Reset after the 4th data bit is on the line.
        d0 = done_cnt; e0 = err_cnt;
        send(8'h00);
        device_frame(1'b1, 1'b0, 4, bits);
        check("pre_reset_drive", {busy, ps2_data_oe}, 2'b11);
        #2 reset = 1'b1;
        #1 check("reset_release", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        tick(5);
        reset = 1'b0;
        tick(20);
        check("reset_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);

        d0 = done_cnt; e0 = err_cnt;
        send(8'hF4);
        device_frame(1'b1, 1'b0, 11, bits);
        wait_ready();
        check("after_reset_bits", bits, ref_frame(8'hF4));
        check("after_reset_done", done_cnt - d0, 1);

        check("never_both", both_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
